// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 64;

    // Instruction region starts here; CPU stores at or above it are blocked
    localparam logic [AW_DEF-1:0] ROM_BASE = 12'h800;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, ACK} state_e;
    typedef enum logic {OWN_CPU, OWN_LD} owner_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signals of the arbiter; slave = arbiter view, master = environment view.
interface ram_port_arbiter_if import ram_arb_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          cpu_stall;
    logic          cpu_wr_fault;

    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic [DW-1:0] ld_rdata;
    logic          ld_ack;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          grant_ld;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall, cpu_wr_fault,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_rdata, ld_ack,
        output ram_addr, ram_we, ram_wdata, grant_ld,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall, cpu_wr_fault,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_rdata, ld_ack,
        input  ram_addr, ram_we, ram_wdata, grant_ld,
        output ram_rdata
    );

endinterface

// File: rtl/ram_arb_prio.sv
// Loader-first priority with a starvation counter that hands the CPU a turn after LD_MAX loader grants.
module ram_arb_prio #(
    parameter int LD_MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic ld_req,
    input  logic arb_en,
    output logic gnt_cpu,
    output logic gnt_ld
);

    logic [7:0] starve_cnt_q;
    logic       cpu_turn;

    assign cpu_turn = cpu_req && (starve_cnt_q == 8'(LD_MAX));
    assign gnt_ld   = arb_en && ld_req && !cpu_turn;
    assign gnt_cpu  = arb_en && cpu_req && !gnt_ld;

    // Counts only loader wins that made the CPU wait
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else if (arb_en) begin
            if (!cpu_req || gnt_cpu) begin
                starve_cnt_q <= '0;
            end else if (gnt_ld) begin
                starve_cnt_q <= starve_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises CPU and loader accesses onto one synchronous single-port RAM, blocking CPU stores to the instruction region.
module ram_port_arbiter import ram_arb_pkg::*; #(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int LD_MAX = 8
) (
    input  logic            clk,
    input  logic            rst,
    ram_port_arbiter_if.slave bus
);

    state_e        state_q;
    owner_e        own_q, own_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          prot_q, prot_d;
    logic [DW-1:0] cpu_rdata_q, ld_rdata_q;
    logic          cpu_ack_q, ld_ack_q;
    logic          fault_q;
    logic          gnt_cpu, gnt_ld;

    ram_arb_prio #(.LD_MAX(LD_MAX)) u_prio (
        .clk     (clk),
        .rst     (rst),
        .cpu_req (bus.cpu_req),
        .ld_req  (bus.ld_req),
        .arb_en  (state_q == IDLE),
        .gnt_cpu (gnt_cpu),
        .gnt_ld  (gnt_ld)
    );

    always_comb begin
        own_d   = gnt_ld ? OWN_LD : OWN_CPU;
        addr_d  = gnt_ld ? bus.ld_addr  : bus.cpu_addr;
        wdata_d = gnt_ld ? bus.ld_wdata : bus.cpu_wdata;
        we_d    = gnt_ld ? bus.ld_we    : bus.cpu_we;
        prot_d  = (own_d == OWN_CPU) && we_d && addr_d[AW-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            own_q       <= OWN_CPU;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            prot_q      <= 1'b0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
            cpu_ack_q   <= 1'b0;
            ld_ack_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            ld_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_cpu || gnt_ld) begin
                        own_q   <= own_d;
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        we_q    <= we_d;
                        prot_q  <= prot_d;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (prot_q) fault_q <= 1'b1;
                    state_q <= RESP;
                end
                // RAM read data for the ISSUE address is valid now
                RESP: begin
                    if (own_q == OWN_LD) begin
                        ld_rdata_q <= bus.ram_rdata;
                        ld_ack_q   <= 1'b1;
                    end else begin
                        cpu_rdata_q <= bus.ram_rdata;
                        cpu_ack_q   <= 1'b1;
                    end
                    state_q <= ACK;
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gating by rst keeps a write caught in ISSUE from landing during reset
    assign bus.ram_we       = (state_q == ISSUE) && we_q && !prot_q && !rst;
    assign bus.ram_addr     = addr_q;
    assign bus.ram_wdata    = wdata_q;
    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.cpu_ack      = cpu_ack_q;
    assign bus.cpu_stall    = bus.cpu_req && !cpu_ack_q;
    assign bus.cpu_wr_fault = fault_q;
    assign bus.ld_rdata     = ld_rdata_q;
    assign bus.ld_ack       = ld_ack_q;
    assign bus.grant_ld     = (own_q == OWN_LD);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural synchronous 4K x 64 RAM.
module tb_ram_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   we_cnt = 0;
    int   we_cyc = -1;

    exp_t        cpu_q[$];
    exp_t        ld_q[$];
    bit          ack_log[$];
    logic [63:0] ref_mem [0:4095];
    logic [63:0] mem [0:4095];
    logic        cpu_pend = 1'b0;
    logic        ld_pend = 1'b0;

    ram_port_arbiter_if #(.AW(12), .DW(64)) bus ();

    ram_port_arbiter #(.AW(12), .DW(64), .LD_MAX(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) begin
            we_cnt <= we_cnt + 1;
            we_cyc <= cyc;
        end
    end

    // Requesters must hold req until ack (reset abandons the request)
    always @(posedge clk) begin
        if (!rst && cpu_pend && !bus.cpu_req && !bus.cpu_ack)
            $error("protocol: cpu_req dropped before cpu_ack at cycle %0d", cyc);
        if (!rst && ld_pend && !bus.ld_req && !bus.ld_ack)
            $error("protocol: ld_req dropped before ld_ack at cycle %0d", cyc);
        cpu_pend <= !rst && !bus.cpu_ack && bus.cpu_req;
        ld_pend  <= !rst && !bus.ld_ack && bus.ld_req;
    end

    task automatic access(input bit is_ld, input logic we, input logic [11:0] a,
                          input logic [63:0] d, output int lat, output logic [63:0] rd);
        exp_t e;
        int   start;
        bit   got;
        e.we   = we;
        e.addr = a;
        e.data = we ? d : ref_mem[a];
        if (we && (is_ld || !a[11])) ref_mem[a] = d;
        if (is_ld) begin
            bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = d; bus.ld_req = 1'b1;
            ld_q.push_back(e);
        end else begin
            bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_req = 1'b1;
            cpu_q.push_back(e);
        end
        start = cyc;
        got   = 1'b0;
        rd    = '0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if ((is_ld ? bus.ld_ack : bus.cpu_ack) === 1'b1) begin
                got = 1'b1;
            end else if (!is_ld) begin
                n_vec++;
                if (bus.cpu_stall !== 1'b1) begin
                    n_fail++;
                    $display("FAIL cpu_stall_wait: got %b want 1 (cycle %0d)", bus.cpu_stall, cyc);
                end
            end
        end
        lat = cyc - start;
        n_vec++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s_ack_timeout: no ack within 100 cycles, want ack for addr %h",
                     is_ld ? "ld" : "cpu", a);
        end else begin
            if (is_ld) begin
                e  = ld_q.pop_front();
                rd = bus.ld_rdata;
            end else begin
                e  = cpu_q.pop_front();
                rd = bus.cpu_rdata;
                if (bus.cpu_stall !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cpu_stall_ack: got %b want 0", bus.cpu_stall);
                end
            end
            ack_log.push_back(is_ld);
            if (!e.we) begin
                n_vec++;
                if (rd !== e.data) begin
                    n_fail++;
                    $display("FAIL %s_rdata[%h]: got %h want %h", is_ld ? "ld" : "cpu", e.addr, rd, e.data);
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        bus.cpu_req = 1'b0;
        bus.ld_req  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.cpu_ack, bus.ld_ack, bus.ram_we, bus.cpu_wr_fault, bus.grant_ld, bus.cpu_stall} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {bus.cpu_ack, bus.ld_ack, bus.ram_we, bus.cpu_wr_fault, bus.grant_ld, bus.cpu_stall});
        end
        n_vec++;
        if ({bus.ram_addr, bus.ram_wdata, bus.cpu_rdata, bus.ld_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got addr %h wdata %h crd %h lrd %h want all 0",
                     bus.ram_addr, bus.ram_wdata, bus.cpu_rdata, bus.ld_rdata);
        end
        rst     = 1'b0;
        mem_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cpu_write_read;
        int lat; int s; int w0; logic [63:0] rd;
        w0 = we_cnt;
        s  = cyc;
        access(1'b0, 1'b1, 12'h010, 64'hDEAD_BEEF_0000_0001, lat, rd);
        n_vec++;
        if (we_cnt - w0 != 1 || we_cyc != s + 1) begin
            n_fail++;
            $display("FAIL cpu_write_we: got %0d pulses at cycle %0d, want 1 at cycle %0d", we_cnt - w0, we_cyc, s + 1);
        end
        n_vec++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL cpu_write_latency: got %0d want 3", lat);
        end
        idle_cycles(1);
        access(1'b0, 1'b0, 12'h010, 64'h0, lat, rd);
        n_vec++;
        if (lat != 3 || rd !== 64'hDEAD_BEEF_0000_0001) begin
            n_fail++;
            $display("FAIL cpu_read_back: got lat %0d data %h want lat 3 data deadbeef00000001", lat, rd);
        end
        idle_cycles(2);
    endtask

    task automatic test_starvation;
        ack_log.delete();
        fork
            begin
                int lat_l; logic [63:0] rd_l;
                for (int i = 0; i < 18; i++) access(1'b1, 1'b1, 12'h200 + 12'(i), ~64'(i), lat_l, rd_l);
                bus.ld_req = 1'b0;
            end
            begin
                int lat_c; logic [63:0] rd_c;
                for (int k = 0; k < 2; k++) begin
                    access(1'b0, 1'b0, 12'h010, 64'h0, lat_c, rd_c);
                    n_vec++;
                    if (lat_c > 36) begin
                        n_fail++;
                        $display("FAIL cpu_wait_bound: got %0d cycles want <= 36", lat_c);
                    end
                end
                bus.cpu_req = 1'b0;
            end
        join
        n_vec++;
        if (ack_log.size() != 20) begin
            n_fail++;
            $display("FAIL starve_ack_count: got %0d want 20", ack_log.size());
        end else begin
            for (int j = 0; j < 20; j++) begin
                n_vec++;
                if (ack_log[j] !== !(j == 8 || j == 17)) begin
                    n_fail++;
                    $display("FAIL starve_order[%0d]: got owner ld=%b want ld=%b", j, ack_log[j], !(j == 8 || j == 17));
                end
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_loader_fill;
        int lat; logic [63:0] rd;
        for (int i = 0; i < 16; i++) access(1'b1, 1'b1, 12'h800 + 12'(i), 64'h800 + 64'(i), lat, rd);
        idle_cycles(1);
        access(1'b0, 1'b0, 12'h805, 64'h0, lat, rd);
        n_vec++;
        if (rd !== 64'h805) begin
            n_fail++;
            $display("FAIL cpu_read_rom: got %h want 805", rd);
        end
        idle_cycles(2);
    endtask

    task automatic test_write_protect;
        int lat; int w0; logic [63:0] rd;
        access(1'b1, 1'b1, 12'h900, 64'h1234, lat, rd);
        idle_cycles(1);
        w0 = we_cnt;
        access(1'b0, 1'b1, 12'h900, 64'hBAD, lat, rd);
        n_vec++;
        if (we_cnt != w0 || bus.cpu_wr_fault !== 1'b1) begin
            n_fail++;
            $display("FAIL protect_write: got %0d ram_we pulses fault %b want 0 pulses fault 1", we_cnt - w0, bus.cpu_wr_fault);
        end
        idle_cycles(3);
        access(1'b1, 1'b0, 12'h900, 64'h0, lat, rd);
        n_vec++;
        if (rd !== 64'h1234 || bus.grant_ld !== 1'b1 || bus.cpu_wr_fault !== 1'b1) begin
            n_fail++;
            $display("FAIL protect_readback: got data %h grant_ld %b fault %b want 1234 1 1", rd, bus.grant_ld, bus.cpu_wr_fault);
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_access;
        int w0; int lat; logic [63:0] rd;
        w0 = we_cnt;
        bus.cpu_we = 1'b1; bus.cpu_addr = 12'h020; bus.cpu_wdata = 64'h55; bus.cpu_req = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_issue_we: got %b want 0", bus.ram_we);
        end
        @(negedge clk);
        n_vec++;
        if ({bus.cpu_ack, bus.ld_ack, bus.cpu_wr_fault, bus.grant_ld} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_mid_ctrl: got %b want 0000", {bus.cpu_ack, bus.ld_ack, bus.cpu_wr_fault, bus.grant_ld});
        end
        n_vec++;
        if ({bus.ram_addr, bus.ram_wdata, bus.cpu_rdata, bus.ld_rdata} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_data: got addr %h wdata %h crd %h lrd %h want all 0",
                     bus.ram_addr, bus.ram_wdata, bus.cpu_rdata, bus.ld_rdata);
        end
        rst = 1'b0;
        bus.cpu_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++;
            if (bus.cpu_ack !== 1'b0 || we_cnt != w0) begin
                n_fail++;
                $display("FAIL rst_abandon: got ack %b we pulses %0d want 0 0", bus.cpu_ack, we_cnt - w0);
            end
        end
        access(1'b0, 1'b0, 12'h020, 64'h0, lat, rd);
        idle_cycles(2);
    endtask

    task automatic test_back_to_back;
        int lat; int w0; logic [63:0] rd;
        w0 = we_cnt;
        for (int i = 0; i < 4; i++) begin
            access(1'b1, 1'b1, 12'h300 + 12'(i), 64'hA0 + 64'(i), lat, rd);
            n_vec++;
            if (lat != ((i == 0) ? 3 : 4)) begin
                n_fail++;
                $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, lat, (i == 0) ? 3 : 4);
            end
        end
        idle_cycles(1);
        n_vec++;
        if (we_cnt - w0 != 4) begin
            n_fail++;
            $display("FAIL b2b_access_count: got %0d want 4", we_cnt - w0);
        end
        access(1'b1, 1'b0, 12'h302, 64'h0, lat, rd);
        idle_cycles(2);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ld_req  = 1'b0; bus.ld_we  = 1'b0; bus.ld_addr  = '0; bus.ld_wdata  = '0;
        @(negedge clk);
        test_reset();
        test_cpu_write_read();
        test_starvation();
        test_loader_fill();
        test_write_protect();
        test_reset_mid_access();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
